// File: rtl/rng_stim_harness.sv
// rng_stim_harness: per-channel Galois LFSR stimulus generators plus a MISR that
// compresses observed outputs into one signature per SIG_PERIOD steps.
module rng_stim_harness #(
    parameter int                    WIDTH      = 32,
    parameter int                    CHANNELS   = 4,
    parameter logic [WIDTH-1:0]      SEED       = 32'h0000_0001,
    parameter logic [WIDTH-1:0]      TAPS       = 32'h8020_0003,
    parameter int                    OBS_WIDTH  = 32,
    parameter int                    MISR_WIDTH = 32,
    parameter logic [MISR_WIDTH-1:0] MISR_TAPS  = 32'h8020_0003,
    parameter int                    SIG_PERIOD = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step_en,
    input  logic [OBS_WIDTH-1:0]         obs_in,
    output logic [CHANNELS*WIDTH-1:0]    rand_out,
    output logic [MISR_WIDTH-1:0]        signature,
    output logic                         sig_valid
);
    localparam int CW = (SIG_PERIOD > 1) ? $clog2(SIG_PERIOD) : 1;

    logic [CHANNELS*WIDTH-1:0] seeds;
    logic [CHANNELS*WIDTH-1:0] state_q, state_d;
    logic [MISR_WIDTH-1:0]     misr_q, misr_d, sig_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      sig_valid_q, last;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        localparam int R = c % WIDTH;
        localparam logic [2*WIDTH-1:0] ROT = {SEED, SEED} << R;
        logic [WIDTH-1:0] s;
        assign seeds[c*WIDTH +: WIDTH] = ROT[2*WIDTH-1 -: WIDTH];
        assign s = state_q[c*WIDTH +: WIDTH];
        // an all-zero state would lock up forever, so reseed instead of stepping
        assign state_d[c*WIDTH +: WIDTH] = (s == '0) ? seeds[c*WIDTH +: WIDTH] :
            ({s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0));
    end

    always_comb begin
        last   = cnt_q == CW'(SIG_PERIOD - 1);
        cnt_d  = last ? '0 : cnt_q + 1'b1;
        misr_d = {misr_q[MISR_WIDTH-2:0], 1'b0} ^ (misr_q[MISR_WIDTH-1] ? MISR_TAPS : '0)
               ^ MISR_WIDTH'(obs_in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= seeds;
            misr_q      <= '0;
            cnt_q       <= '0;
            sig_q       <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            sig_valid_q <= step_en && last;
            if (step_en) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                misr_q  <= last ? '0 : misr_d;
                if (last) sig_q <= misr_d;
            end
        end
    end

    assign rand_out  = state_q;
    assign signature = sig_q;
    assign sig_valid = sig_valid_q;
endmodule

// File: doc/rng_stim_harness.md
RNG_STIM_HARNESS -- requirements
Module: rng_stim_harness

Interface
- REQ-001 The module SHALL have parameter WIDTH, default 32, giving the bits per random channel.
- REQ-002 The module SHALL have parameter CHANNELS, default 4, giving the number of independent LFSR channels (1..16).
- REQ-003 The module SHALL have parameter SEED, default 32'h0000_0001, a WIDTH-bit nonzero base seed.
- REQ-004 The module SHALL have parameter TAPS, default 32'h8020_0003, the WIDTH-bit Galois feedback mask (bit 0 SHALL be set).
- REQ-005 The module SHALL have parameter OBS_WIDTH, default 32, the observed DUT output width (1..MISR_WIDTH).
- REQ-006 The module SHALL have parameter MISR_WIDTH, default 32, the signature register width.
- REQ-007 The module SHALL have parameter MISR_TAPS, default 32'h8020_0003, the MISR feedback mask.
- REQ-008 The module SHALL have parameter SIG_PERIOD, default 1024, the steps per signature window (>=1).
- REQ-009 Port clk, input, 1 bit: single clock; all state SHALL be rising-edge.
- REQ-010 Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-011 Port step_en, input, 1 bit: advance all LFSRs, MISR and window counter this cycle.
- REQ-012 Port rand_out, output, CHANNELS*WIDTH bits: channel c occupies bits [c*WIDTH +: WIDTH], driven directly from registers.
- REQ-013 Port obs_in, input, OBS_WIDTH bits: DUT outputs to compress.
- REQ-014 Port signature, output, MISR_WIDTH bits: the last completed window signature.
- REQ-015 Port sig_valid, output, 1 bit: one-cycle pulse when signature updates.

Function
- REQ-016 Galois step g(s, M) SHALL be {s[N-2:0],1'b0} XOR (s[N-1] ? M : 0), where N is the width of s.
- REQ-017 The seed of channel c SHALL be SEED rotated left by (c mod WIDTH) bits.
- REQ-018 On each cycle with step_en=1, each channel state SHALL become g(state, TAPS).
- REQ-019 When step_en=0, all LFSR states, the MISR, the counter and signature SHALL hold.
- REQ-020 If a channel state is ever all-zero, its next state SHALL be its seed instead of g() (lockup guard).
- REQ-021 The MISR SHALL update on step_en to g(misr, MISR_TAPS) XOR zero-extended obs_in sampled that cycle.
- REQ-022 The window counter SHALL count step_en cycles from 0 to SIG_PERIOD-1 and then wrap to 0.
- REQ-023 On the step where the counter equals SIG_PERIOD-1, signature SHALL load the updated MISR value (including that cycle's obs_in), the MISR SHALL clear to 0, and sig_valid SHALL be 1 on the following cycle only.
- REQ-024 sig_valid SHALL be 0 in all other cycles, including while step_en=0.
- REQ-025 rand_out SHALL change exactly one cycle after the step_en edge with no combinational path from any input.

Reset
- REQ-026 While reset=1, each channel SHALL load its seed, and the MISR, counter, signature and sig_valid SHALL be 0; reset SHALL override step_en.
- REQ-027 Reset asserted mid-window SHALL discard the partial window with no sig_valid pulse.
- REQ-028 After reset deasserts, the first step_en SHALL produce g(seed) on each channel.

Verification
- REQ-029 Scenario 1: WIDTH=8, CHANNELS=2, SEED=8'h01, TAPS=8'h71, reset -> rand_out = 16'h0201; after 1 step -> 16'h0402; after 8 steps, channel 0 = 8'h71.
- REQ-030 Scenario 2: step_en held 0 for 50 cycles after reset -> rand_out stays at the seeds, and signature=0 and sig_valid=0.
- REQ-031 Scenario 3: MISR_WIDTH=8, MISR_TAPS=8'h71, SIG_PERIOD=1, obs_in=8'h01 on one step -> next cycle signature=8'h01, sig_valid=1 for 1 cycle, MISR=0.
- REQ-032 Scenario 4: SIG_PERIOD=4, obs_in=0, continuous step_en -> sig_valid pulses every 4 cycles with signature=0.
- REQ-033 Scenario 5: reset asserted after 2 of 4 window steps -> no sig_valid, all state back to seeds and 0; the next pulse occurs 4 steps later.
- REQ-034 Scenario 6: force channel state to 0 via the bench -> next step loads the seed, not 0.
